// File: rtl/issue_queue_mp_pkg.sv
// Shared defaults, the per-entry record and the lane helpers used by the issue queue.
package iq_pkg;

  localparam int IQ_DEPTH     = 64;
  localparam int IQ_ENQ_W     = 4;
  localparam int IQ_DEQ_W     = 2;
  localparam int IQ_FWD_PORTS = 4;
  localparam int IQ_TAG_W     = 6;
  localparam int IQ_DATA_W    = 16;
  localparam int IQ_OP_W      = 4;

  typedef struct packed {
    logic [IQ_OP_W-1:0]   op;
    logic [IQ_TAG_W-1:0]  rob;
    logic [IQ_TAG_W-1:0]  tag_a;
    logic [IQ_TAG_W-1:0]  tag_b;
    logic [IQ_DATA_W-1:0] val_a;
    logic [IQ_DATA_W-1:0] val_b;
    logic                 pend_a;
    logic                 pend_b;
    logic                 valid;
  } iq_entry_t;

  // Packs one enqueue lane's unpacked fields into a valid entry record.
  function automatic iq_entry_t iq_make_entry(
    input logic [IQ_OP_W-1:0]   op,
    input logic [IQ_TAG_W-1:0]  rob,
    input logic [IQ_TAG_W-1:0]  tag_a,
    input logic [IQ_TAG_W-1:0]  tag_b,
    input logic [IQ_DATA_W-1:0] val_a,
    input logic [IQ_DATA_W-1:0] val_b,
    input logic                 pend_a,
    input logic                 pend_b
  );
    iq_entry_t e;
    e.op     = op;
    e.rob    = rob;
    e.tag_a  = tag_a;
    e.tag_b  = tag_b;
    e.val_a  = val_a;
    e.val_b  = val_b;
    e.pend_a = pend_a;
    e.pend_b = pend_b;
    e.valid  = 1'b1;
    return e;
  endfunction

  // Resolved operands are left untouched; only pending ones capture a broadcast.
  function automatic iq_entry_t iq_apply_fwd(
    input iq_entry_t            e,
    input logic                 hit_a,
    input logic [IQ_DATA_W-1:0] data_a,
    input logic                 hit_b,
    input logic [IQ_DATA_W-1:0] data_b
  );
    iq_entry_t r;
    r = e;
    if (e.pend_a && hit_a) begin
      r.val_a  = data_a;
      r.pend_a = 1'b0;
    end
    if (e.pend_b && hit_b) begin
      r.val_b  = data_b;
      r.pend_b = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/issue_queue_mp_fwd_match.sv
// Compares one operand tag with every result bus; the lowest-numbered matching bus wins.
module iq_fwd_match #(
  parameter int FWD_PORTS = 4,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 16
) (
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [FWD_PORTS-1:0]        fwd_valid_i,
  input  logic [FWD_PORTS*TAG_W-1:0]  fwd_tag_i,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_data_i,
  output logic                        hit_o,
  output logic [DATA_W-1:0]           data_o
);

  // Scanning downward lets the lowest index overwrite any higher match.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int p = FWD_PORTS - 1; p >= 0; p--) begin
      if (fwd_valid_i[p] && (fwd_tag_i[p*TAG_W +: TAG_W] == tag_i)) begin
        hit_o  = 1'b1;
        data_o = fwd_data_i[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/issue_queue_mp.sv
// Circular in-order issue queue: compacting multi-lane enqueue, operand wakeup from
// result broadcasts (including bypass into enqueuing lanes) and an in-order head window.
module issue_queue_mp
  import iq_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int ENQ_W     = IQ_ENQ_W,
  parameter int DEQ_W     = IQ_DEQ_W,
  parameter int FWD_PORTS = IQ_FWD_PORTS,
  parameter int TAG_W     = IQ_TAG_W,
  parameter int DATA_W    = IQ_DATA_W,
  parameter int OP_W      = IQ_OP_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [ENQ_W-1:0]              enq_valid,
  input  logic [ENQ_W*OP_W-1:0]         enq_op,
  input  logic [ENQ_W*TAG_W-1:0]        enq_rob,
  input  logic [ENQ_W*TAG_W-1:0]        enq_tag_a,
  input  logic [ENQ_W*TAG_W-1:0]        enq_tag_b,
  input  logic [ENQ_W*DATA_W-1:0]       enq_val_a,
  input  logic [ENQ_W*DATA_W-1:0]       enq_val_b,
  input  logic [ENQ_W-1:0]              enq_pend_a,
  input  logic [ENQ_W-1:0]              enq_pend_b,
  output logic                          enq_ready,
  output logic [$clog2(DEPTH+1)-1:0]    free_count,
  input  logic [FWD_PORTS-1:0]          fwd_valid,
  input  logic [FWD_PORTS*TAG_W-1:0]    fwd_tag,
  input  logic [FWD_PORTS*DATA_W-1:0]   fwd_data,
  output logic [DEQ_W-1:0]              deq_valid,
  output logic [DEQ_W-1:0]              deq_opready,
  output logic [DEQ_W*OP_W-1:0]         deq_op,
  output logic [DEQ_W*TAG_W-1:0]        deq_rob,
  output logic [DEQ_W*TAG_W-1:0]        deq_tag_a,
  output logic [DEQ_W*TAG_W-1:0]        deq_tag_b,
  output logic [DEQ_W*DATA_W-1:0]       deq_val_a,
  output logic [DEQ_W*DATA_W-1:0]       deq_val_b,
  output logic [DEQ_W-1:0]              deq_pend_a,
  output logic [DEQ_W-1:0]              deq_pend_b,
  input  logic [$clog2(DEQ_W+1)-1:0]    deq_take
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  iq_entry_t     mem_q   [DEPTH];
  iq_entry_t     mem_d   [DEPTH];
  iq_entry_t     fwd_ent [DEPTH];
  iq_entry_t     lane_ent[ENQ_W];
  logic [PW-1:0] enq_tgt [ENQ_W];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, rel;
  logic [CW-1:0] count_q, count_d, lane_cnt, acc_n, avail, take_n;

  genvar gi;

  assign free_count = CW'(DEPTH) - count_q;
  assign enq_ready  = (free_count >= CW'(ENQ_W));

  // Wakeup of stored entries: both operands of every slot watch all buses.
  for (gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic              hit_a, hit_b;
    logic [DATA_W-1:0] data_a, data_b;
    iq_fwd_match #(.FWD_PORTS(FWD_PORTS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_match_a (
      .tag_i(mem_q[gi].tag_a), .fwd_valid_i(fwd_valid), .fwd_tag_i(fwd_tag),
      .fwd_data_i(fwd_data), .hit_o(hit_a), .data_o(data_a)
    );
    iq_fwd_match #(.FWD_PORTS(FWD_PORTS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_match_b (
      .tag_i(mem_q[gi].tag_b), .fwd_valid_i(fwd_valid), .fwd_tag_i(fwd_tag),
      .fwd_data_i(fwd_data), .hit_o(hit_b), .data_o(data_b)
    );
    assign fwd_ent[gi] = iq_apply_fwd(mem_q[gi], hit_a, data_a, hit_b, data_b);
  end

  // Bypass: an incoming lane sees the same broadcasts as resident entries.
  for (gi = 0; gi < ENQ_W; gi++) begin : g_lane
    logic              hit_a, hit_b;
    logic [DATA_W-1:0] data_a, data_b;
    iq_fwd_match #(.FWD_PORTS(FWD_PORTS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_match_a (
      .tag_i(enq_tag_a[gi*TAG_W +: TAG_W]), .fwd_valid_i(fwd_valid), .fwd_tag_i(fwd_tag),
      .fwd_data_i(fwd_data), .hit_o(hit_a), .data_o(data_a)
    );
    iq_fwd_match #(.FWD_PORTS(FWD_PORTS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_match_b (
      .tag_i(enq_tag_b[gi*TAG_W +: TAG_W]), .fwd_valid_i(fwd_valid), .fwd_tag_i(fwd_tag),
      .fwd_data_i(fwd_data), .hit_o(hit_b), .data_o(data_b)
    );
    assign lane_ent[gi] = iq_apply_fwd(
      iq_make_entry(enq_op[gi*OP_W +: OP_W], enq_rob[gi*TAG_W +: TAG_W],
                    enq_tag_a[gi*TAG_W +: TAG_W], enq_tag_b[gi*TAG_W +: TAG_W],
                    enq_val_a[gi*DATA_W +: DATA_W], enq_val_b[gi*DATA_W +: DATA_W],
                    enq_pend_a[gi], enq_pend_b[gi]),
      hit_a, data_a, hit_b, data_b);
  end

  // Each set lane lands at tail plus the number of set lanes below it.
  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      enq_tgt[i] = tail_q + PW'(lane_cnt);
      lane_cnt   = lane_cnt + CW'(enq_valid[i]);
    end
    acc_n  = enq_ready ? lane_cnt : '0;
    avail  = (count_q < CW'(DEQ_W)) ? count_q : CW'(DEQ_W);
    take_n = (CW'(deq_take) < avail) ? CW'(deq_take) : avail;
  end

  // Enqueue targets lie in the free region and never alias the taken head slots.
  always_comb begin
    rel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rel      = PW'(k) - head_q;
      mem_d[k] = fwd_ent[k];
      if (CW'(rel) < take_n) begin
        mem_d[k].valid = 1'b0;
      end
      for (int i = 0; i < ENQ_W; i++) begin
        if (enq_ready && enq_valid[i] && (enq_tgt[i] == PW'(k))) begin
          mem_d[k] = lane_ent[i];
        end
      end
    end
  end

  assign head_d  = head_q + PW'(take_n);
  assign tail_d  = tail_q + PW'(acc_n);
  assign count_d = count_q + acc_n - take_n;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k].valid <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  for (gi = 0; gi < DEQ_W; gi++) begin : g_deq
    logic [PW-1:0] idx;
    assign idx = head_q + PW'(gi);
    assign deq_valid[gi]                  = (CW'(gi) < count_q);
    assign deq_opready[gi]                = deq_valid[gi] & ~mem_q[idx].pend_a & ~mem_q[idx].pend_b;
    assign deq_op[gi*OP_W +: OP_W]        = mem_q[idx].op;
    assign deq_rob[gi*TAG_W +: TAG_W]     = mem_q[idx].rob;
    assign deq_tag_a[gi*TAG_W +: TAG_W]   = mem_q[idx].tag_a;
    assign deq_tag_b[gi*TAG_W +: TAG_W]   = mem_q[idx].tag_b;
    assign deq_val_a[gi*DATA_W +: DATA_W] = mem_q[idx].val_a;
    assign deq_val_b[gi*DATA_W +: DATA_W] = mem_q[idx].val_b;
    assign deq_pend_a[gi]                 = mem_q[idx].pend_a;
    assign deq_pend_b[gi]                 = mem_q[idx].pend_b;
  end

endmodule

// File: tb/tb_issue_queue_mp.sv
// Bench for issue_queue_mp: directed scenarios plus random traffic against a queue-based model.
module tb_issue_queue_mp;

  localparam int DEPTH = 64;
  localparam int ENQ_W = 4;
  localparam int DEQ_W = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [3:0]  enq_valid, enq_pend_a, enq_pend_b;
  logic [15:0] enq_op;
  logic [23:0] enq_rob, enq_tag_a, enq_tag_b;
  logic [63:0] enq_val_a, enq_val_b;
  logic        enq_ready;
  logic [6:0]  free_count;
  logic [3:0]  fwd_valid;
  logic [23:0] fwd_tag;
  logic [63:0] fwd_data;
  logic [1:0]  deq_valid, deq_opready, deq_pend_a, deq_pend_b, deq_take;
  logic [7:0]  deq_op;
  logic [11:0] deq_rob, deq_tag_a, deq_tag_b;
  logic [31:0] deq_val_a, deq_val_b;

  issue_queue_mp dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_op(enq_op), .enq_rob(enq_rob),
    .enq_tag_a(enq_tag_a), .enq_tag_b(enq_tag_b),
    .enq_val_a(enq_val_a), .enq_val_b(enq_val_b),
    .enq_pend_a(enq_pend_a), .enq_pend_b(enq_pend_b),
    .enq_ready(enq_ready), .free_count(free_count),
    .fwd_valid(fwd_valid), .fwd_tag(fwd_tag), .fwd_data(fwd_data),
    .deq_valid(deq_valid), .deq_opready(deq_opready),
    .deq_op(deq_op), .deq_rob(deq_rob), .deq_tag_a(deq_tag_a), .deq_tag_b(deq_tag_b),
    .deq_val_a(deq_val_a), .deq_val_b(deq_val_b),
    .deq_pend_a(deq_pend_a), .deq_pend_b(deq_pend_b),
    .deq_take(deq_take)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [5:0]  rob, tag_a, tag_b;
    logic [15:0] val_a, val_b;
    logic        pend_a, pend_b;
  } ment_t;

  ment_t mq[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc_n  = 0;
  int    seq    = 0;
  bit    chk_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // First matching bus in ascending order resolves the operand.
  function automatic ment_t fwd_apply(input ment_t e);
    ment_t r = e;
    for (int p = 0; p < 4; p++) begin
      if (r.pend_a && fwd_valid[p] && fwd_tag[p*6 +: 6] == r.tag_a) begin
        r.val_a = fwd_data[p*16 +: 16]; r.pend_a = 1'b0;
      end
      if (r.pend_b && fwd_valid[p] && fwd_tag[p*6 +: 6] == r.tag_b) begin
        r.val_b = fwd_data[p*16 +: 16]; r.pend_b = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic void model_step();
    int    sz, lim, n;
    ment_t e;
    sz = mq.size();
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      foreach (mq[i]) mq[i] = fwd_apply(mq[i]);
      lim = (sz < DEQ_W) ? sz : DEQ_W;
      n   = (int'(deq_take) > lim) ? lim : int'(deq_take);
      repeat (n) void'(mq.pop_front());
      if (DEPTH - sz >= ENQ_W) begin
        for (int l = 0; l < ENQ_W; l++) begin
          if (enq_valid[l]) begin
            e.op = enq_op[l*4 +: 4];     e.rob = enq_rob[l*6 +: 6];
            e.tag_a = enq_tag_a[l*6 +: 6]; e.tag_b = enq_tag_b[l*6 +: 6];
            e.val_a = enq_val_a[l*16 +: 16]; e.val_b = enq_val_b[l*16 +: 16];
            e.pend_a = enq_pend_a[l];    e.pend_b = enq_pend_b[l];
            mq.push_back(fwd_apply(e));
          end
        end
      end
    end
    $display("cyc %0d rst_n=%0b flush=%0b enq=%b take=%0d fwd=%b -> count=%0d",
             cyc_n, rst_n, flush, enq_valid, deq_take, fwd_valid, mq.size());
  endfunction

  always @(negedge clk) begin : cmp
    int    sz;
    ment_t e;
    if (chk_en) begin
      sz = mq.size();
      chk("free_count", 32'(free_count), 32'(DEPTH - sz));
      chk("enq_ready", 32'(enq_ready), 32'(sz <= DEPTH - ENQ_W));
      for (int j = 0; j < DEQ_W; j++) begin
        chk("deq_valid", 32'(deq_valid[j]), 32'(j < sz));
        if (j < sz) begin
          e = mq[j];
          chk("deq_op", 32'(deq_op[j*4 +: 4]), 32'(e.op));
          chk("deq_rob", 32'(deq_rob[j*6 +: 6]), 32'(e.rob));
          chk("deq_tag_a", 32'(deq_tag_a[j*6 +: 6]), 32'(e.tag_a));
          chk("deq_tag_b", 32'(deq_tag_b[j*6 +: 6]), 32'(e.tag_b));
          chk("deq_val_a", 32'(deq_val_a[j*16 +: 16]), 32'(e.val_a));
          chk("deq_val_b", 32'(deq_val_b[j*16 +: 16]), 32'(e.val_b));
          chk("deq_pend_a", 32'(deq_pend_a[j]), 32'(e.pend_a));
          chk("deq_pend_b", 32'(deq_pend_b[j]), 32'(e.pend_b));
          chk("deq_opready", 32'(deq_opready[j]), 32'(!e.pend_a && !e.pend_b));
        end else begin
          chk("deq_opready_idle", 32'(deq_opready[j]), 32'd0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
  endtask

  task automatic idle();
    enq_valid = '0; deq_take = '0; fwd_valid = '0; flush = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic [5:0] rob, input logic [5:0] ta,
                          input logic [15:0] va, input logic pa, input logic [5:0] tbg,
                          input logic [15:0] vb, input logic pb);
    enq_op[l*4 +: 4]     = rob[3:0];
    enq_rob[l*6 +: 6]    = rob;
    enq_tag_a[l*6 +: 6]  = ta;
    enq_tag_b[l*6 +: 6]  = tbg;
    enq_val_a[l*16 +: 16] = va;
    enq_val_b[l*16 +: 16] = vb;
    enq_pend_a[l] = pa;
    enq_pend_b[l] = pb;
  endtask

  task automatic fill_group(input logic [3:0] mask);
    for (int l = 0; l < ENQ_W; l++) begin
      set_lane(l, 6'(seq), 6'(seq + 1), 16'(seq * 3), 1'b0, 6'(seq + 2), 16'(seq * 5), 1'b0);
      seq++;
    end
    enq_valid = mask;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    enq_op = '0; enq_rob = '0; enq_tag_a = '0; enq_tag_b = '0;
    enq_val_a = '0; enq_val_b = '0; enq_pend_a = '0; enq_pend_b = '0;
    fwd_tag = '0; fwd_data = '0;
    idle();
    cyc();
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;

    // Reset state
    chk("rst_free_count", 32'(free_count), 32'd64);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_deq_opready", 32'(deq_opready), 32'd0);

    // Sparse lanes compact into consecutive slots
    set_lane(1, 6'd5, 6'd0, 16'h0001, 1'b0, 6'd0, 16'h0002, 1'b0);
    set_lane(3, 6'd7, 6'd0, 16'h0003, 1'b0, 6'd0, 16'h0004, 1'b0);
    enq_valid = 4'b1010;
    cyc(); idle();
    chk("compact_valid", 32'(deq_valid), 32'h3);
    chk("compact_rob0", 32'(deq_rob[5:0]), 32'd5);
    chk("compact_rob1", 32'(deq_rob[11:6]), 32'd7);
    chk("compact_free", 32'(free_count), 32'd62);
    deq_take = 2'd2;
    cyc(); idle();

    // Wakeup of a resident entry from port 2
    set_lane(0, 6'd10, 6'd9, 16'h0000, 1'b1, 6'd0, 16'h1234, 1'b0);
    enq_valid = 4'b0001;
    cyc(); idle();
    chk("wake_before", 32'(deq_opready[0]), 32'd0);
    fwd_valid = 4'b0100; fwd_tag[17:12] = 6'd9; fwd_data[47:32] = 16'hBEEF;
    cyc(); idle();
    chk("wake_val_a", 32'(deq_val_a[15:0]), 32'hBEEF);
    chk("wake_pend_a", 32'(deq_pend_a[0]), 32'd0);
    chk("wake_opready", 32'(deq_opready[0]), 32'd1);
    deq_take = 2'd1;
    cyc(); idle();

    // Bypass into an enqueuing lane, port 0 beats port 1
    set_lane(2, 6'd11, 6'd0, 16'h0005, 1'b0, 6'd3, 16'h0000, 1'b1);
    enq_valid = 4'b0100;
    fwd_valid = 4'b0011;
    fwd_tag[5:0] = 6'd3;  fwd_data[15:0]  = 16'h0042;
    fwd_tag[11:6] = 6'd3; fwd_data[31:16] = 16'h1111;
    cyc(); idle();
    chk("bypass_val_b", 32'(deq_val_b[15:0]), 32'h0042);
    chk("bypass_pend_b", 32'(deq_pend_b[0]), 32'd0);
    deq_take = 2'd1;
    cyc(); idle();

    // Fill to 61: the group is dropped until space frees up
    for (int g = 0; g < 15; g++) fill_group(4'hF);
    fill_group(4'b0001);
    idle();
    chk("full_free", 32'(free_count), 32'd3);
    chk("full_ready", 32'(enq_ready), 32'd0);
    fill_group(4'hF);
    idle();
    chk("drop_free", 32'(free_count), 32'd3);
    deq_take = 2'd2;
    cyc(); idle();
    chk("drain_free", 32'(free_count), 32'd5);
    chk("drain_ready", 32'(enq_ready), 32'd1);

    // Walk head to 62, then wrap
    flush = 1'b1;
    cyc(); idle();
    for (int i = 0; i < 31; i++) begin
      deq_take = 2'd2;
      fill_group(4'b0011);
    end
    idle();
    deq_take = 2'd2;
    cyc(); idle();
    chk("wrap_empty", 32'(free_count), 32'd64);
    for (int l = 0; l < 4; l++) set_lane(l, 6'(40 + l), 6'd0, 16'(l), 1'b0, 6'd0, 16'(l), 1'b0);
    enq_valid = 4'hF;
    cyc(); idle();
    chk("wrap_rob62", 32'(deq_rob[5:0]), 32'd40);
    chk("wrap_rob63", 32'(deq_rob[11:6]), 32'd41);
    deq_take = 2'd2;
    cyc(); idle();
    chk("wrap_rob0", 32'(deq_rob[5:0]), 32'd42);
    chk("wrap_rob1", 32'(deq_rob[11:6]), 32'd43);
    for (int i = 0; i < 10; i++) begin
      deq_take = 2'd2;
      fill_group(4'hF);
    end
    idle();

    // Flush and reset with enqueue/take in the same cycle
    flush = 1'b1;
    cyc(); idle();
    fill_group(4'hF); fill_group(4'hF); fill_group(4'b0011);
    idle();
    chk("ten_free", 32'(free_count), 32'd54);
    flush = 1'b1; enq_valid = 4'hF; deq_take = 2'd2;
    cyc(); idle();
    chk("flush_valid", 32'(deq_valid), 32'd0);
    chk("flush_free", 32'(free_count), 32'd64);
    fill_group(4'hF); fill_group(4'hF); fill_group(4'b0011);
    idle();
    rst_n = 1'b0; enq_valid = 4'hF; deq_take = 2'd2;
    cyc();
    rst_n = 1'b1; idle();
    chk("rst_mid_valid", 32'(deq_valid), 32'd0);
    chk("rst_mid_free", 32'(free_count), 32'd64);

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      enq_valid = 4'($urandom_range(0, 15));
      for (int l = 0; l < ENQ_W; l++) begin
        set_lane(l, 6'($urandom), 6'($urandom_range(0, 7)), 16'($urandom), 1'($urandom),
                 6'($urandom_range(0, 7)), 16'($urandom), 1'($urandom));
      end
      fwd_valid = 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++) begin
        fwd_tag[p*6 +: 6]   = 6'($urandom_range(0, 7));
        fwd_data[p*16 +: 16] = 16'($urandom);
      end
      deq_take = 2'($urandom_range(0, 3));
      flush    = ($urandom_range(0, 199) == 0);
      rst_n    = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rst_n = 1'b1; idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_queue_mp.md
Name: issue_queue_mp

Overview:
- Parametrised successor of the 4-in/2-out issue queue: circular in-order buffer of renamed µops between rename/dispatch and the execute units.
- Each entry holds opcode, ROB tag, two source tags/values and per-operand pending bits, captured from FWD_PORTS result-broadcast buses.
- New in this generation: backpressure, real flush, compacting enqueue, same-cycle forward bypass into enqueuing entries, and per-lane operand-ready outputs.

Parameters:
DEPTH, 64, entries; power of 2, >= ENQ_W + DEQ_W
ENQ_W, 4, enqueue lanes per cycle
DEQ_W, 2, head lanes presented per cycle
FWD_PORTS, 4, result broadcast buses
TAG_W, 6, ROB/source tag width
DATA_W, 16, operand width
OP_W, 4, opcode width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous clear of all entries
enq_valid  in  ENQ_W  per-lane request; any bit pattern legal
enq_op  in  ENQ_W*OP_W  lane-packed opcode, lane 0 in LSBs
enq_rob  in  ENQ_W*TAG_W  destination ROB tag
enq_tag_a / enq_tag_b  in  ENQ_W*TAG_W  source tags
enq_val_a / enq_val_b  in  ENQ_W*DATA_W  source values (meaningful when not pending)
enq_pend_a / enq_pend_b  in  ENQ_W  operand still awaits broadcast
enq_ready  out  1  group accepted this cycle
free_count  out  clog2(DEPTH+1)  free entries
fwd_valid  in  FWD_PORTS  broadcast valid
fwd_tag  in  FWD_PORTS*TAG_W  broadcast tag
fwd_data  in  FWD_PORTS*DATA_W  broadcast value
deq_valid  out  DEQ_W  lane j holds entry head+j
deq_opready  out  DEQ_W  lane j has both operands resolved
deq_op, deq_rob, deq_tag_a, deq_tag_b, deq_val_a, deq_val_b, deq_pend_a, deq_pend_b  out  DEQ_W-packed  entry fields
deq_take  in  clog2(DEQ_W+1)  head entries consumed this cycle

Behaviour:
- Reset (rst_n=0 at posedge): head=tail=count=0, all valid bits cleared. Outputs: deq_valid=0, deq_opready=0, free_count=DEPTH, enq_ready=1. Priority: rst_n > flush > normal operation.
- free_count = DEPTH - count, from registered count. enq_ready = (free_count >= ENQ_W), combinational from registers only.
- Enqueue: when enq_ready=1, the set lanes of enq_valid are compacted in ascending lane order into tail, tail+1, ... mod DEPTH; tail += popcount. When enq_ready=0, the entire group is dropped and upstream holds it. No partial acceptance.
- Enqueue latency: an entry written at edge N is visible on deq lanes from cycle N+1.
- Forwarding (every cycle, all valid entries):
  - For each pending operand, if fwd_valid[p] and fwd_tag[p]==operand tag, latch fwd_data[p] and clear the pending bit.
  - If several ports match, the lowest p wins.
  - The same match is applied to enqueuing lanes before write (bypass), so a broadcast coinciding with enqueue is never lost.
  - Operands with pending=0 are never overwritten.
- Dequeue outputs (combinational reads of storage):
  - deq_valid[j] = (j < count).
  - deq_opready[j] = deq_valid[j] & ~pend_a & ~pend_b.
  - Fields are don't-care when deq_valid[j]=0.
- Dequeue consumption:
  - deq_take = n consumes head..head+n-1: valid bits cleared, head += n.
  - n is clamped to the number of valid lanes.
  - The consumer only takes an in-order prefix; the queue does not check opready.
- count_next = count + accepted - taken. Entries freed this cycle are not reusable until next cycle; enqueue space comes from registered count only.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally. Lanes head+j and compaction targets wrap mod DEPTH.
- Full: count=DEPTH gives free_count=0, enq_ready=0. Empty: count=0 gives deq_valid=0.
- Flush: at next edge, all valid bits cleared and head=tail=count=0. Enqueue, take and forward in the flush cycle are ignored.

Decomposition:
- Package iq_pkg: parameter defaults, iq_entry_t struct (op, rob, tag_a, tag_b, val_a, val_b, pend_a, pend_b, valid), lane-pack/unpack helper functions.
- Sub-module iq_fwd_match: one operand vs FWD_PORTS buses, outputs hit + data with lowest-index priority. Instantiated 2 per entry and 2 per enqueue lane.

Test Plan:
- Reset with rst_n=0, then enq_valid=4'b1010 carrying rob 5 and 7 -> next cycle deq_valid=2'b11, lane0 rob=5, lane1 rob=7, free_count=62.
- Entry with pend_a=1, tag_a=9; pulse fwd port 2 tag 9 data 0xBEEF -> next cycle deq_val_a=0xBEEF, pend_a=0, deq_opready=1.
- Enqueue lane with pend_b=1, tag_b=3 in the same cycle fwd port 0 broadcasts tag 3 data 0x0042, and port 1 also broadcasts tag 3 -> entry lands with val_b=0x0042, pend_b=0 (port 0 wins).
- Fill to count=61 -> enq_ready=0 and a 4-lane group is dropped. Then deq_take=2 -> next cycle free_count=5, enq_ready=1.
- Place head at 62, enqueue 4 and take 2 repeatedly -> lanes wrap 63 to 0 correctly, with no lost or duplicated rob tags.
- With 10 entries, assert flush together with enq_valid=4'hF and deq_take=2 -> next cycle count=0, deq_valid=0, free_count=64. Reassert rst_n=0 mid-stream -> same result.
